// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit
//   Iterative multiply/divide unit with HI/LO registers. It sits beside the EX-stage ALU.
//   - mult/multu/div/divu run for WIDTH+1 busy cycles: WIDTH RUN steps, then one FIX step.
//   - mthi/mtlo write HI/LO in a single cycle.
//   - mfhi/mflo are combinational reads on Result.
// Ports:
//   clk, reset   : core clock; synchronous active-high reset
//   Start, Funct : EX-stage HI/LO instruction request and its R-type function field
//   A, B         : rs / rt operands
//   Cancel       : pipeline flush; aborts a requested or running operation
//   Busy         : multi-cycle operation in progress
//   Stall        : Start & Busy (combinational)
//   Done         : one-cycle pulse after mult/div has written HI/LO
//   Result       : HI for mfhi, LO for mflo, otherwise zero (combinational)
//   HI, LO       : HI/LO registers
module alu_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cancel,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0]    S_IDLE   = 2'd0;
  localparam logic [1:0]    S_RUN    = 2'd1;
  localparam logic [1:0]    S_FIX    = 2'd2;
  localparam logic [5:0]    F_MFHI   = 6'b010000;
  localparam logic [5:0]    F_MTHI   = 6'b010001;
  localparam logic [5:0]    F_MFLO   = 6'b010010;
  localparam logic [5:0]    F_MTLO   = 6'b010011;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Two's-complement negate when neg is set (single half).
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Two's-complement negate when neg is set (full double-width product).
  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Lower half: multiplier / dividend->quotient. Upper half: partial product / remainder.
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;   // multiplicand or divisor magnitude
  logic               is_div_q, is_div_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               accept_s, is_md_s, md_start_s, a_neg_s, b_neg_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_shl_s;
  logic               div_ge_s;
  logic [WIDTH-1:0]   div_rem_s;
  logic [2*WIDTH-1:0] mul_full_s;

  // Request decode: Cancel beats Start, and nothing is accepted while busy.
  always_comb begin
    accept_s   = Start & ~Cancel & (state_q == S_IDLE);
    is_md_s    = (Funct[5:2] == 4'b0110);
    md_start_s = accept_s & is_md_s;
    // Funct[0]=0 selects the signed variant.
    a_neg_s    = ~Funct[0] & A[WIDTH-1];
    b_neg_s    = ~Funct[0] & B[WIDTH-1];
  end

  // One iteration step for shift-add multiply and restoring divide.
  always_comb begin
    mul_sum_s  = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
               + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    div_shl_s  = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    div_ge_s   = (div_shl_s >= {1'b0, mcand_q});
    // When the trial subtraction succeeds, the difference is below the divisor, so WIDTH bits suffice.
    div_rem_s  = div_ge_s ? (div_shl_s[WIDTH-1:0] - mcand_q) : div_shl_s[WIDTH-1:0];
    mul_full_s = cond_neg2(prod_q, sign_a_q ^ sign_b_q);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (md_start_s) state_d = S_RUN;
        else            state_d = S_IDLE;
      end
      S_RUN: begin
        if (Cancel)                 state_d = S_IDLE;
        else if (cnt_q == CNT_LAST) state_d = S_FIX;
        else                        state_d = S_RUN;
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs and the combinational read/stall paths.
  always_comb begin
    Busy  = (state_q != S_IDLE);
    Stall = Start & Busy;
    case (Funct)
      F_MFHI:  Result = hi_q;
      F_MFLO:  Result = lo_q;
      default: Result = {WIDTH{1'b0}};
    endcase
  end

  // Datapath next-state: operand latch, iteration, sign fix-up and HI/LO writes.
  always_comb begin
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (md_start_s) begin
          prod_d   = {{WIDTH{1'b0}}, cond_neg(A, a_neg_s)};
          mcand_d  = cond_neg(B, b_neg_s);
          is_div_d = Funct[1];
          sign_a_d = a_neg_s;
          sign_b_d = b_neg_s;
          cnt_d    = {CW{1'b0}};
        end else if (accept_s && (Funct == F_MTHI)) begin
          hi_d = A;
        end else if (accept_s && (Funct == F_MTLO)) begin
          lo_d = A;
        end else begin
          hi_d = hi_q;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CNT_ONE;
        if (is_div_q) prod_d = {div_rem_s, prod_q[WIDTH-2:0], div_ge_s};
        else          prod_d = {mul_sum_s, prod_q[WIDTH-1:1]};
      end
      S_FIX: begin
        if (Cancel) begin
          done_d = 1'b0;
        end else if (is_div_q) begin
          done_d = 1'b1;
          lo_d   = cond_neg(prod_q[WIDTH-1:0], sign_a_q ^ sign_b_q);
          hi_d   = cond_neg(prod_q[2*WIDTH-1:WIDTH], sign_a_q);
        end else begin
          done_d = 1'b1;
          hi_d   = mul_full_s[2*WIDTH-1:WIDTH];
          lo_d   = mul_full_s[WIDTH-1:0];
        end
      end
      default: done_d = 1'b0;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= {CW{1'b0}};
      prod_q   <= {(2*WIDTH){1'b0}};
      mcand_q  <= {WIDTH{1'b0}};
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign HI   = hi_q;
  assign LO   = lo_q;
  assign Done = done_q;

endmodule

// File: doc/alu_muldiv_unit.md
Name: alu_muldiv_unit

Overview:
Iterative multiply/divide unit with HI/LO registers for the pipelined MIPS core. It sits beside the EX-stage ALU and is selected when the R-type Funct field encodes a HI/LO operation. It generalises the ALU decode path in two ways: operand width is a parameter, and operations take multiple cycles with a busy/stall handshake. The hazard unit uses Stall to freeze IF/ID/EX while an HI/LO access conflicts with a running operation.

Parameters:
WIDTH, 32, operand width and HI/LO register width in bits (even, at least 4).

Ports:
clk  in  1  core clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
Start  in  1  EX-stage instruction is a valid R-type HI/LO operation this cycle.
Funct  in  6  R-type function field.
A  in  WIDTH  rs operand.
B  in  WIDTH  rt operand.
Cancel  in  1  pipeline flush; aborts the current or requested operation.
Busy  out  1  multi-cycle operation in progress.
Stall  out  1  combinational; equals Start & Busy.
Done  out  1  one-cycle pulse; HI/LO just updated by mult/div.
Result  out  WIDTH  combinational; HI if Funct=010000 (mfhi), LO if Funct=010010 (mflo), otherwise 0.
HI  out  WIDTH  HI register.
LO  out  WIDTH  LO register.

Behaviour:
- Reset (synchronous, active-high): state IDLE; HI=0, LO=0, Busy=0, Done=0; counter and work registers cleared. Reset in any state, including mid-operation, discards the operation.
- Funct decode:
  - 011000 mult, 011001 multu, 011010 div, 011011 divu.
  - 010000 mfhi, 010001 mthi, 010010 mflo, 010011 mtlo.
  - Signed when Funct[0]=0 for mult/div.
  - Any other Funct with Start=1 is ignored.
- Acceptance: Start is accepted only when Busy=0 and Cancel=0.
  - If Start and Cancel are both 1, Cancel wins: nothing is accepted and no state changes.
  - Start while Busy=1 is not accepted; it raises Stall, and the pipeline holds and re-presents the instruction.
- mthi/mtlo accepted: HI (or LO) takes A at the same edge; single cycle; Busy stays 0 and no Done pulse.
- mfhi/mflo: purely combinational read of Result. During Busy=1 they stall via Stall, so stale data is never consumed.
- State machine, IDLE -> RUN -> FIX -> IDLE:
  - IDLE: on an accepted mult/div, latch operand magnitudes (abs when signed) and the result signs, clear counter, go to RUN.
  - RUN: one bit per cycle for WIDTH cycles; counter runs 0..WIDTH-1.
    - Multiply: shift-add over a 2*WIDTH product.
    - Divide: restoring division, one quotient bit per cycle.
    - At counter=WIDTH-1, go to FIX.
  - FIX: apply sign correction.
    - Product is negated if sign(A)^sign(B).
    - Quotient sign is sign(A)^sign(B); remainder sign is sign(A).
    - Write HI/LO (mult: HI=upper half, LO=lower half; div: LO=quotient, HI=remainder).
    - Assert Done for the next cycle; go to IDLE.
- Latency: Busy is high for exactly WIDTH+1 cycles, starting the cycle after the accepting edge. Done=1 and HI/LO show new values in the first cycle with Busy=0. A new Start may be accepted in that same cycle.
- Cancel while Busy: return to IDLE at the next edge; HI/LO unchanged; no Done.
- Divide by zero:
  - divu: LO=all ones, HI=A.
  - div: LO = -1 if A>=0, +1 if A<0; HI=A. This follows from the sign rule applied to the all-ones magnitude quotient.
- Signed overflow: div of most-negative by -1 gives LO=most-negative and HI=0 (wraps, no trap).
- Widths: all arithmetic is modulo 2^WIDTH per half; negation is two's complement.

Test Plan:
- multu A=0xFFFFFFFF, B=0xFFFFFFFF -> Busy high 33 cycles, then Done=1 with HI=0xFFFFFFFE, LO=0x00000001.
- mult A=0xFFFFFFFD (-3), B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; then mfhi gives Result=0xFFFFFFFF.
- div A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu A=7, B=0 -> LO=0xFFFFFFFF, HI=7. Then div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start mflo at cycle 5 of a running mult -> Stall=1 until Busy falls; in the Done cycle Result equals the new LO.
- Start divu, then Cancel at cycle 10 -> Busy=0 next cycle, no Done, HI/LO retain prior values. Start+Cancel together with mthi A=0x1234 -> HI unchanged.
- mtlo A=0xABCD when idle -> LO=0xABCD next cycle, Busy=0. Assert reset at RUN cycle 7 -> HI=LO=0, Busy=0, Done=0. Re-run with WIDTH=8: multu 0xFF*0xFF -> HI=0xFE, LO=0x01 after 9 Busy cycles.
